// File: rtl/mode_comparator_pkg.sv
// Shared constants for the mode_comparator max/min selector.
package mode_comparator_pkg;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mode_comparator_mag.sv
// Combinational magnitude compare of two WIDTH-bit operands, unsigned or two's-complement.
module mode_comparator_mag #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq
);

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;

    assign ka = a ^ FLIP;
    assign kb = b ^ FLIP;
    assign gt = (ka > kb);
    assign eq = (a == b);

endmodule

// File: rtl/mode_comparator.sv
// Registered max/min selector with win/equality flags and one cycle of latency.
module mode_comparator
    import mode_comparator_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             sel_b,
    output logic             eq,
    output logic             a_gt_b
);

    logic             a_gt_b_c;
    logic             eq_c;
    logic             sel_b_c;

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q,      y_d;
    logic             sel_b_q,  sel_b_d;
    logic             eq_q,     eq_d;
    logic             a_gt_b_q, a_gt_b_d;

    mode_comparator_mag #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_mag (
        .a  (a),
        .b  (b),
        .gt (a_gt_b_c),
        .eq (eq_c)
    );

    // Ties resolve to operand a in both modes.
    assign sel_b_c = (m == MODE_MAX) ? (~a_gt_b_c & ~eq_c) : a_gt_b_c;

    always_comb begin
        y_d      = y_q;
        sel_b_d  = sel_b_q;
        eq_d     = eq_q;
        a_gt_b_d = a_gt_b_q;
        if (in_valid) begin
            y_d      = sel_b_c ? b : a;
            sel_b_d  = sel_b_c;
            eq_d     = eq_c;
            a_gt_b_d = a_gt_b_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sel_b_q     <= 1'b0;
            eq_q        <= 1'b0;
            a_gt_b_q    <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            y_q         <= y_d;
            sel_b_q     <= sel_b_d;
            eq_q        <= eq_d;
            a_gt_b_q    <= a_gt_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sel_b     = sel_b_q;
    assign eq        = eq_q;
    assign a_gt_b    = a_gt_b_q;

endmodule

// File: tb/tb_mode_comparator.sv
// Randomized and directed checks of mode_comparator (unsigned and signed instances) against a value-level model.
module tb_mode_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;

    logic       u_out_valid, u_sel_b, u_eq, u_a_gt_b;
    logic [7:0] u_y;
    logic       s_out_valid, s_sel_b, s_eq, s_a_gt_b;
    logic [7:0] s_y;

    int errors = 0;
    int checks = 0;

    // Result packing: {out_valid, sel_b, eq, a_gt_b, y}
    logic [11:0] exp_u, exp_s;
    logic [11:0] obs_u, obs_s;
    assign obs_u = {u_out_valid, u_sel_b, u_eq, u_a_gt_b, u_y};
    assign obs_s = {s_out_valid, s_sel_b, s_eq, s_a_gt_b, s_y};

    always #5 clk = ~clk;

    mode_comparator #(.WIDTH(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .m(m),
        .out_valid(u_out_valid), .y(u_y), .sel_b(u_sel_b), .eq(u_eq), .a_gt_b(u_a_gt_b)
    );

    mode_comparator #(.WIDTH(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .m(m),
        .out_valid(s_out_valid), .y(s_y), .sel_b(s_sel_b), .eq(s_eq), .a_gt_b(s_a_gt_b)
    );

    // Reference: compare numeric values, pick the larger (MAX) or smaller (MIN); ties keep a.
    function automatic logic [11:0] ref_result(input logic [7:0] aa, input logic [7:0] bb,
                                               input logic mm, input bit sgn);
        int va, vb;
        logic pick_b;
        if (sgn) begin
            va = $signed(aa);
            vb = $signed(bb);
        end else begin
            va = int'(aa);
            vb = int'(bb);
        end
        pick_b = (mm == 1'b0) ? (vb > va) : (va > vb);
        return {1'b1, pick_b, (va == vb), (va > vb), (pick_b ? bb : aa)};
    endfunction

    task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic mm);
        @(negedge clk);
        in_valid = v;
        a        = aa;
        b        = bb;
        m        = mm;
        @(posedge clk);
        #1;
        if (v) begin
            exp_u = ref_result(aa, bb, mm, 1'b0);
            exp_s = ref_result(aa, bb, mm, 1'b1);
        end else begin
            exp_u[11] = 1'b0;
            exp_s[11] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; m = 1'b0;
        exp_u = '0; exp_s = '0;
        #2;
        checks++;
        if (obs_u !== 12'h000 || obs_s !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got u=%h s=%h want 000", obs_u, obs_s);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs_u !== 12'h000 || obs_s !== 12'h000) begin
            errors++;
            $display("FAIL reset_release: got u=%h s=%h want 000", obs_u, obs_s);
        end
        $display("test_reset done");
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'd33, 8'd167, 8'd68, 8'd5, 8'd112, 8'd132};
        logic [7:0] tb [6] = '{8'd122, 8'd4, 8'd68, 8'd5, 8'd103, 8'd141};
        logic       tm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] ty [6] = '{8'd122, 8'd167, 8'd68, 8'd5, 8'd103, 8'd132};
        logic       ts [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ta[i], tb[i], tm[i]);
            checks++;
            if (obs_u !== exp_u) begin
                errors++;
                $display("FAIL directed_model[%0d]: got %h want %h", i, obs_u, exp_u);
            end
            checks++;
            if (u_y !== ty[i] || u_sel_b !== ts[i] || u_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed_const[%0d]: got y=%0d sel_b=%b v=%b want y=%0d sel_b=%b v=1",
                         i, u_y, u_sel_b, u_out_valid, ty[i], ts[i]);
            end
            $display("directed a=%0d b=%0d m=%b -> y=%0d sel_b=%b eq=%b gt=%b",
                     ta[i], tb[i], tm[i], u_y, u_sel_b, u_eq, u_a_gt_b);
        end
    endtask

    task automatic test_signed();
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        checks++;
        if (s_y !== 8'h01 || obs_s !== exp_s) begin
            errors++;
            $display("FAIL signed_max: got y=%h flags=%h want y=01 flags=%h", s_y, obs_s, exp_s);
        end
        checks++;
        if (u_y !== 8'hFF || obs_u !== exp_u) begin
            errors++;
            $display("FAIL unsigned_max_ff: got y=%h want y=ff", u_y);
        end
        $display("signed max FF vs 01 -> s_y=%h u_y=%h", s_y, u_y);
        drive(1'b1, 8'h80, 8'h7F, 1'b1);
        checks++;
        if (s_y !== 8'h80 || obs_s !== exp_s) begin
            errors++;
            $display("FAIL signed_min: got y=%h flags=%h want y=80 flags=%h", s_y, obs_s, exp_s);
        end
        checks++;
        if (u_y !== 8'h7F || obs_u !== exp_u) begin
            errors++;
            $display("FAIL unsigned_min_80: got y=%h want y=7f", u_y);
        end
        $display("signed min 80 vs 7F -> s_y=%h u_y=%h", s_y, u_y);
        drive(1'b1, 8'h00, 8'hFF, 1'b0);
        checks++;
        if (obs_u !== exp_u || obs_s !== exp_s) begin
            errors++;
            $display("FAIL extremes_00_ff: got u=%h s=%h want u=%h s=%h", obs_u, obs_s, exp_u, exp_s);
        end
        $display("extremes 00 vs FF max -> u_y=%h s_y=%h", u_y, s_y);
    endtask

    task automatic test_hold();
        drive(1'b1, 8'd200, 8'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'($urandom), 8'($urandom), ~m);
            checks++;
            if (obs_u !== exp_u || obs_s !== exp_s || u_y !== 8'd200) begin
                errors++;
                $display("FAIL hold[%0d]: got u=%h s=%h want u=%h s=%h", i, obs_u, obs_s, exp_u, exp_s);
            end
            $display("hold cycle %0d: out_valid=%b y=%0d", i, u_out_valid, u_y);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra, rb;
        logic       rv, rm;
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rm = 1'($urandom);
            case ($urandom_range(0, 5))
                0: begin ra = 8'h80; rb = 8'h7F; end
                1: begin ra = 8'h00; rb = 8'hFF; end
                2: begin ra = 8'($urandom); rb = ra; end
                default: begin ra = 8'($urandom); rb = 8'($urandom); end
            endcase
            drive(rv, ra, rb, rm);
            checks++;
            if (obs_u !== exp_u || obs_s !== exp_s) begin
                errors++;
                $display("FAIL stream[%0d]: v=%b a=%h b=%h m=%b got u=%h s=%h want u=%h s=%h",
                         i, rv, ra, rb, rm, obs_u, obs_s, exp_u, exp_s);
            end
            $display("stream %0d v=%b a=%h b=%h m=%b -> u=%h s=%h", i, rv, ra, rb, rm, obs_u, obs_s);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'd9, 8'd250, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; a = 8'd77; b = 8'd66; m = 1'b0;
        #1 rst = 1'b1;
        #1;
        exp_u = '0; exp_s = '0;
        checks++;
        if (obs_u !== 12'h000 || obs_s !== 12'h000) begin
            errors++;
            $display("FAIL midstream_reset: got u=%h s=%h want 000", obs_u, obs_s);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_u !== 12'h000 || obs_s !== 12'h000) begin
            errors++;
            $display("FAIL reset_discard: got u=%h s=%h want 000", obs_u, obs_s);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        drive(1'b1, 8'd77, 8'd66, 1'b1);
        checks++;
        if (obs_u !== exp_u || obs_s !== exp_s || u_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first: got u=%h s=%h want u=%h s=%h", obs_u, obs_s, exp_u, exp_s);
        end
        $display("async reset: first result after release y=%0d out_valid=%b", u_y, u_out_valid);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_signed();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
